memory_stage: RTL and testbench

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 171 +++++++++++++++++
 tb/tb_memory_stage.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_stage.sv
// ---------------------------------------------------------------------------
// memory_stage
//
// Memory stage of the pipeline. It holds the EX/MEM pipeline register and
// runs a small IDLE/ACCESS controller that drives a request/acknowledge
// memory port. It also feeds the MEM/WB pipeline register. While an access
// waits for mem_ack, upstream stages are frozen through 'stall' and bubbles
// are pushed into MEM/WB. An access that never gets acknowledged is
// abandoned after TIMEOUT+1 cycles. In that case the load data reads as zero
// and the sticky mem_err flag is raised.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-low reset
//   IRegWrite..IRd       operation fields coming from the Execute stage
//   mem_req/we/addr/
//   wdata/rdata/ack      memory request/acknowledge port
//   stall                freeze request towards upstream stages
//   ALUResultMEM         EX/MEM ALU result, used for forwarding
//   ORegWrite..ORd       MEM/WB register outputs
//   loadDataWB           MEM/WB load data
//   mem_err              sticky access-timeout flag
// ---------------------------------------------------------------------------
module memory_stage #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IRegWrite,
    input  logic        IRegStore,
    input  logic        IMemWrite,
    input  logic        IMemRead,
    input  logic [15:0] IPCP2,
    input  logic [15:0] IALUResult,
    input  logic [15:0] I3rdArg,
    input  logic [15:0] IRd,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    output logic        stall,
    output logic [15:0] ALUResultMEM,
    output logic        ORegWrite,
    output logic        ORegStore,
    output logic        OMemRead,
    output logic [15:0] OPCP2,
    output logic [15:0] OALUResult,
    output logic [15:0] loadDataWB,
    output logic [15:0] ORd,
    output logic        mem_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } fsmState;

    localparam logic [3:0] TIMEOUT_COUNT = 4'(TIMEOUT);

    fsmState     state;
    logic [3:0]  waitCount;

    logic        exRegWrite;
    logic        exRegStore;
    logic        exMemWrite;
    logic        exMemRead;
    logic [15:0] exPCP2;
    logic [15:0] exAluResult;
    logic [15:0] exThirdArg;
    logic [15:0] exRd;

    logic        accessing;
    logic        timeoutHit;
    logic        advance;
    logic        loadAcked;

    // The timeout fires only on a cycle with no acknowledge, so a late ack
    // on the last allowed cycle still completes as a normal access.
    assign accessing  = (state == ACCESS);
    assign timeoutHit = accessing && (waitCount == TIMEOUT_COUNT) && !mem_ack;
    assign stall      = accessing && !mem_ack && !timeoutHit;
    assign advance    = !stall;
    assign loadAcked  = accessing && mem_ack && exMemRead;

    // Memory port is a pure decode of the registered state. Address and write
    // data are parked at zero while idle.
    assign mem_req      = accessing;
    assign mem_we       = accessing && exMemWrite;
    assign mem_addr     = accessing ? exAluResult : 16'h0000;
    assign mem_wdata    = accessing ? exThirdArg  : 16'h0000;
    assign ALUResultMEM = exAluResult;

    // Access controller. Whenever the stage advances, the incoming operation
    // decides whether the next cycle is an access. This lets back-to-back
    // memory ops issue without an idle cycle. The wait counter restarts on
    // every advance and counts only the cycles spent waiting for mem_ack.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            waitCount <= 4'd0;
            mem_err   <= 1'b0;
        end else if (advance) begin
            state     <= (IMemRead || IMemWrite) ? ACCESS : IDLE;
            waitCount <= 4'd0;
            if (timeoutHit) begin
                mem_err <= 1'b1;
            end
        end else begin
            waitCount <= waitCount + 4'd1;
        end
    end

    // EX/MEM register: frozen while the stage is stalled on memory.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            exRegWrite  <= 1'b0;
            exRegStore  <= 1'b0;
            exMemWrite  <= 1'b0;
            exMemRead   <= 1'b0;
            exPCP2      <= 16'h0000;
            exAluResult <= 16'h0000;
            exThirdArg  <= 16'h0000;
            exRd        <= 16'h0000;
        end else if (advance) begin
            exRegWrite  <= IRegWrite;
            exRegStore  <= IRegStore;
            exMemWrite  <= IMemWrite;
            exMemRead   <= IMemRead;
            exPCP2      <= IPCP2;
            exAluResult <= IALUResult;
            exThirdArg  <= I3rdArg;
            exRd        <= IRd;
        end
    end

    // MEM/WB register. A stalled cycle inserts a bubble by clearing only the
    // control flags; the data fields keep their last values. Load data is
    // captured only on a completing access: read data for an acknowledged
    // load, or zero when the access times out.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ORegWrite  <= 1'b0;
            ORegStore  <= 1'b0;
            OMemRead   <= 1'b0;
            OPCP2      <= 16'h0000;
            OALUResult <= 16'h0000;
            ORd        <= 16'h0000;
            loadDataWB <= 16'h0000;
        end else begin
            if (stall) begin
                ORegWrite <= 1'b0;
                ORegStore <= 1'b0;
                OMemRead  <= 1'b0;
            end else begin
                ORegWrite  <= exRegWrite;
                ORegStore  <= exRegStore;
                OMemRead   <= exMemRead;
                OPCP2      <= exPCP2;
                OALUResult <= exAluResult;
                ORd        <= exRd;
            end
            if (loadAcked) begin
                loadDataWB <= mem_rdata;
            end else if (timeoutHit) begin
                loadDataWB <= 16'h0000;
            end
        end
    end

endmodule

// File: tb/tb_memory_stage.sv
// ---------------------------------------------------------------------------
// tb_memory_stage
//
// Directed scenarios for reset, a non-memory op, a load with wait states,
// a zero-wait store followed by a load, an access timeout, and reset during
// an access. These are followed by a randomized stream of operations. The
// bench plays the role of the memory: it keeps an array of contents and
// acknowledges each access after a chosen number of wait cycles. Expected
// stage behaviour comes from per-operation latency rules and that memory array.
// ---------------------------------------------------------------------------
module tb_memory_stage;

    typedef struct {
        logic        regWrite;
        logic        regStore;
        logic        memWrite;
        logic        memRead;
        logic [15:0] pcp2;
        logic [15:0] aluResult;
        logic [15:0] thirdArg;
        logic [15:0] rd;
        int          waits;
    } opRec;

    logic        clk;
    logic        reset;
    logic        IRegWrite;
    logic        IRegStore;
    logic        IMemWrite;
    logic        IMemRead;
    logic [15:0] IPCP2;
    logic [15:0] IALUResult;
    logic [15:0] I3rdArg;
    logic [15:0] IRd;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic        stall;
    logic [15:0] ALUResultMEM;
    logic        ORegWrite;
    logic        ORegStore;
    logic        OMemRead;
    logic [15:0] OPCP2;
    logic [15:0] OALUResult;
    logic [15:0] loadDataWB;
    logic [15:0] ORd;
    logic        mem_err;

    int checks   = 0;
    int failures = 0;

    memory_stage #(.TIMEOUT(15)) dut (
        .clk          (clk),
        .reset        (reset),
        .IRegWrite    (IRegWrite),
        .IRegStore    (IRegStore),
        .IMemWrite    (IMemWrite),
        .IMemRead     (IMemRead),
        .IPCP2        (IPCP2),
        .IALUResult   (IALUResult),
        .I3rdArg      (I3rdArg),
        .IRd          (IRd),
        .mem_req      (mem_req),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata),
        .mem_ack      (mem_ack),
        .stall        (stall),
        .ALUResultMEM (ALUResultMEM),
        .ORegWrite    (ORegWrite),
        .ORegStore    (ORegStore),
        .OMemRead     (OMemRead),
        .OPCP2        (OPCP2),
        .OALUResult   (OALUResult),
        .loadDataWB   (loadDataWB),
        .ORd          (ORd),
        .mem_err      (mem_err)
    );

    // Free-running clock: rising edges at 5, 15, 25, ... and falling edges
    // at 10, 20, ...; all driving and sampling happens around falling edges.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Guard against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input opRec op);
        IRegWrite  = op.regWrite;
        IRegStore  = op.regStore;
        IMemWrite  = op.memWrite;
        IMemRead   = op.memRead;
        IPCP2      = op.pcp2;
        IALUResult = op.aluResult;
        I3rdArg    = op.thirdArg;
        IRd        = op.rd;
    endtask

    function automatic opRec makeOp(input logic rw, input logic rs, input logic mw,
                                    input logic mr, input logic [15:0] pc,
                                    input logic [15:0] alu, input logic [15:0] arg,
                                    input logic [15:0] rd, input int waits);
        opRec op;
        op.regWrite  = rw;
        op.regStore  = rs;
        op.memWrite  = mw;
        op.memRead   = mr;
        op.pcp2      = pc;
        op.aluResult = alu;
        op.thirdArg  = arg;
        op.rd        = rd;
        op.waits     = waits;
        return op;
    endfunction

    opRec        nop;
    opRec        cur;
    opRec        prev;
    opRec        ops[$];
    logic [15:0] memModel [0:7];
    logic [15:0] expLoad;
    logic [15:0] addr;
    bit          isMem;
    int          cycles;
    int          kind;
    int          reqCycles;

    initial begin
        nop = makeOp(0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0);

        // ---- reset state, then a plain ALU op ----
        reset     = 1'b0;
        mem_ack   = 1'b0;
        mem_rdata = 16'h0000;
        applyStimulus(makeOp(1, 0, 0, 0, 16'h0002, 16'h1234, 16'h0000, 16'h0003, 0));
        #2;
        checkOutput("rstStall", stall, 0);
        checkOutput("rstMemReq", mem_req, 0);
        checkOutput("rstMemWe", mem_we, 0);
        checkOutput("rstMemAddr", mem_addr, 16'h0000);
        checkOutput("rstMemWdata", mem_wdata, 16'h0000);
        checkOutput("rstAluMem", ALUResultMEM, 16'h0000);
        checkOutput("rstRegWrite", ORegWrite, 0);
        checkOutput("rstRegStore", ORegStore, 0);
        checkOutput("rstMemRead", OMemRead, 0);
        checkOutput("rstPCP2", OPCP2, 16'h0000);
        checkOutput("rstAluWB", OALUResult, 16'h0000);
        checkOutput("rstLoadData", loadDataWB, 16'h0000);
        checkOutput("rstRd", ORd, 16'h0000);
        checkOutput("rstMemErr", mem_err, 0);
        @(negedge clk);
        checkOutput("rstHoldAluMem", ALUResultMEM, 16'h0000);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("aluOpEdge1Alu", ALUResultMEM, 16'h1234);
        checkOutput("aluOpEdge1Stall", stall, 0);
        checkOutput("aluOpEdge1Req", mem_req, 0);
        applyStimulus(nop);
        @(negedge clk);
        checkOutput("aluOpEdge2Alu", OALUResult, 16'h1234);
        checkOutput("aluOpEdge2RegWrite", ORegWrite, 1);
        checkOutput("aluOpEdge2Rd", ORd, 16'h0003);
        checkOutput("aluOpEdge2Stall", stall, 0);

        // ---- load from 0x0040 acknowledged after three wait cycles ----
        applyStimulus(makeOp(1, 1, 0, 1, 16'h0010, 16'h0040, 16'h0000, 16'h0005, 3));
        reqCycles = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (c > 0) checkOutput($sformatf("waitLoadBubble%0d", c), ORegWrite, 0);
            applyStimulus(nop);
            mem_ack   = (c == 3);
            mem_rdata = (c == 3) ? 16'hBEEF : 16'h1111;
            #1;
            if (mem_req) reqCycles++;
            checkOutput($sformatf("waitLoadStall%0d", c), stall, (c < 3));
            checkOutput($sformatf("waitLoadAddr%0d", c), mem_addr, 16'h0040);
            checkOutput($sformatf("waitLoadWe%0d", c), mem_we, 0);
        end
        checkOutput("waitLoadReqCycles", 16'(reqCycles), 16'd4);
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("waitLoadData", loadDataWB, 16'hBEEF);
        checkOutput("waitLoadRegStore", ORegStore, 1);
        checkOutput("waitLoadRegWrite", ORegWrite, 1);
        checkOutput("waitLoadRd", ORd, 16'h0005);
        #1;
        checkOutput("waitLoadReqAfter", mem_req, 0);

        // ---- zero-wait store to 0x0010 directly followed by a zero-wait load ----
        applyStimulus(makeOp(0, 0, 1, 0, 16'h0020, 16'h0010, 16'h00AA, 16'h0000, 0));
        @(negedge clk);
        applyStimulus(makeOp(1, 1, 0, 1, 16'h0022, 16'h0020, 16'h0000, 16'h0007, 0));
        mem_ack   = 1'b1;
        mem_rdata = 16'h5A5A;
        #1;
        checkOutput("b2bStoreReq", mem_req, 1);
        checkOutput("b2bStoreWe", mem_we, 1);
        checkOutput("b2bStoreAddr", mem_addr, 16'h0010);
        checkOutput("b2bStoreWdata", mem_wdata, 16'h00AA);
        checkOutput("b2bStoreStall", stall, 0);
        @(negedge clk);
        checkOutput("b2bStoreWBRegWrite", ORegWrite, 0);
        checkOutput("b2bStoreWBMemRead", OMemRead, 0);
        checkOutput("b2bStoreLoadHold", loadDataWB, 16'hBEEF);
        applyStimulus(nop);
        mem_ack   = 1'b1;
        mem_rdata = 16'h1357;
        #1;
        checkOutput("b2bLoadReq", mem_req, 1);
        checkOutput("b2bLoadWe", mem_we, 0);
        checkOutput("b2bLoadAddr", mem_addr, 16'h0020);
        checkOutput("b2bLoadStall", stall, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("b2bLoadData", loadDataWB, 16'h1357);
        checkOutput("b2bLoadMemRead", OMemRead, 1);
        checkOutput("b2bLoadRd", ORd, 16'h0007);
        #1;
        checkOutput("b2bReqAfter", mem_req, 0);

        // ---- load that is never acknowledged ----
        checkOutput("toMemErrBefore", mem_err, 0);
        applyStimulus(makeOp(1, 1, 0, 1, 16'h0030, 16'h0050, 16'h0000, 16'h0002, 0));
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            applyStimulus(nop);
            mem_ack   = 1'b0;
            mem_rdata = 16'hFFFF;
            #1;
            checkOutput($sformatf("toStall%0d", c), stall, (c < 15));
            checkOutput($sformatf("toReq%0d", c), mem_req, 1);
        end
        @(negedge clk);
        checkOutput("toLoadData", loadDataWB, 16'h0000);
        checkOutput("toMemErr", mem_err, 1);
        #1;
        checkOutput("toStallAfter", stall, 0);
        checkOutput("toReqAfter", mem_req, 0);
        applyStimulus(makeOp(1, 1, 0, 1, 16'h0032, 16'h0060, 16'h0000, 16'h0004, 0));
        @(negedge clk);
        applyStimulus(nop);
        mem_ack   = 1'b1;
        mem_rdata = 16'h4242;
        #1;
        checkOutput("toNextStall", stall, 0);
        checkOutput("toNextReq", mem_req, 1);
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("toNextLoadData", loadDataWB, 16'h4242);
        checkOutput("toMemErrSticky", mem_err, 1);

        // ---- reset pulse during the second wait cycle of a load ----
        applyStimulus(makeOp(1, 1, 0, 1, 16'h0040, 16'h0070, 16'h0000, 16'h0009, 0));
        @(negedge clk);
        applyStimulus(nop);
        mem_ack = 1'b0;
        #1;
        checkOutput("rstMidWait1Stall", stall, 1);
        @(negedge clk);
        #1;
        checkOutput("rstMidWait2Req", mem_req, 1);
        reset = 1'b0;
        #1;
        checkOutput("rstMidReq", mem_req, 0);
        checkOutput("rstMidStall", stall, 0);
        checkOutput("rstMidMemErr", mem_err, 0);
        checkOutput("rstMidAluMem", ALUResultMEM, 16'h0000);
        checkOutput("rstMidAddr", mem_addr, 16'h0000);
        checkOutput("rstMidRd", ORd, 16'h0000);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("rstRelRegWrite", ORegWrite, 0);
        checkOutput("rstRelMemRead", OMemRead, 0);
        checkOutput("rstRelLoadData", loadDataWB, 16'h0000);
        checkOutput("rstRelReq", mem_req, 0);
        mem_ack   = 1'b1;
        mem_rdata = 16'hDEAD;
        #1;
        checkOutput("idleAckStall", stall, 0);
        checkOutput("idleAckReq", mem_req, 0);
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("idleAckLoadData", loadDataWB, 16'h0000);

        // ---- randomized operation stream against the latency/memory model ----
        for (int k = 0; k < 8; k++) memModel[k] = 16'($urandom);
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 2);
            addr = 16'h0100 + 16'($urandom_range(0, 7));
            if (kind == 0)
                ops.push_back(makeOp(1'($urandom), 0, 0, 0, 16'($urandom), 16'($urandom),
                                     16'($urandom), 16'($urandom), 0));
            else if (kind == 1)
                ops.push_back(makeOp(0, 0, 1, 0, 16'($urandom), addr, 16'($urandom),
                                     16'($urandom), $urandom_range(0, 4)));
            else
                ops.push_back(makeOp(1, 1, 0, 1, 16'($urandom), addr, 16'($urandom),
                                     16'($urandom), $urandom_range(0, 4)));
        end
        ops.push_back(nop);
        expLoad = 16'h0000;
        applyStimulus(ops[0]);
        for (int i = 0; i < ops.size(); i++) begin
            cur    = ops[i];
            isMem  = cur.memRead || cur.memWrite;
            cycles = isMem ? cur.waits + 1 : 1;
            for (int c = 0; c < cycles; c++) begin
                @(negedge clk);
                if (c == 0 && i > 0) begin
                    prev = ops[i-1];
                    checkOutput($sformatf("rnd%0dRegWrite", i-1), ORegWrite, prev.regWrite);
                    checkOutput($sformatf("rnd%0dRegStore", i-1), ORegStore, prev.regStore);
                    checkOutput($sformatf("rnd%0dMemRead", i-1), OMemRead, prev.memRead);
                    checkOutput($sformatf("rnd%0dPCP2", i-1), OPCP2, prev.pcp2);
                    checkOutput($sformatf("rnd%0dAluWB", i-1), OALUResult, prev.aluResult);
                    checkOutput($sformatf("rnd%0dRd", i-1), ORd, prev.rd);
                    checkOutput($sformatf("rnd%0dLoadData", i-1), loadDataWB, expLoad);
                    checkOutput($sformatf("rnd%0dMemErr", i-1), mem_err, 0);
                end else if (c > 0) begin
                    checkOutput($sformatf("rnd%0dBubbleRW%0d", i, c), ORegWrite, 0);
                    checkOutput($sformatf("rnd%0dBubbleMR%0d", i, c), OMemRead, 0);
                end
                if (i + 1 < ops.size()) applyStimulus(ops[i+1]);
                else applyStimulus(nop);
                mem_ack   = isMem ? (c == cur.waits) : 1'($urandom);
                mem_rdata = (isMem && cur.memRead && c == cur.waits)
                            ? memModel[cur.aluResult[2:0]] : 16'($urandom);
                #1;
                checkOutput($sformatf("rnd%0dStall%0d", i, c), stall, isMem && (c < cur.waits));
                checkOutput($sformatf("rnd%0dReq%0d", i, c), mem_req, isMem);
                checkOutput($sformatf("rnd%0dAluMem%0d", i, c), ALUResultMEM, cur.aluResult);
                if (isMem) begin
                    checkOutput($sformatf("rnd%0dWe%0d", i, c), mem_we, cur.memWrite);
                    checkOutput($sformatf("rnd%0dAddr%0d", i, c), mem_addr, cur.aluResult);
                    checkOutput($sformatf("rnd%0dWdata%0d", i, c), mem_wdata, cur.thirdArg);
                    if (c == cur.waits) begin
                        if (cur.memWrite) memModel[cur.aluResult[2:0]] = cur.thirdArg;
                        if (cur.memRead) expLoad = memModel[cur.aluResult[2:0]];
                    end
                end
            end
        end
        @(negedge clk);
        mem_ack = 1'b0;
        checkOutput("rndTailRegWrite", ORegWrite, 0);
        checkOutput("rndTailLoadData", loadDataWB, expLoad);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
